// File: rtl/regfile_read_port_if.sv
// ---------------------------------------------------------------------------
// regfile_read_port_if
//   Request/response handshake bundle between decode (master) and the
//   register-file read sequencer (slave).
//
//   Request  : req_valid, req_ready, req_rs1, req_rs2
//   Response : resp_valid, resp_ready, resp_data1, resp_data2
//
//   master : decode side, drives the request and resp_ready
//   slave  : read sequencer, drives req_ready and the response
// ---------------------------------------------------------------------------
interface regfile_read_port_if #(
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 16
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_rs1;
  logic [ADDR_W-1:0] req_rs2;
  logic              resp_valid;
  logic              resp_ready;
  logic [WIDTH-1:0]  resp_data1;
  logic [WIDTH-1:0]  resp_data2;

  modport master (
    output req_valid, req_rs1, req_rs2, resp_ready,
    input  req_ready, resp_valid, resp_data1, resp_data2
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, resp_ready,
    output req_ready, resp_valid, resp_data1, resp_data2
  );
endinterface

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
//   Read-side sequencer for the bit-cell register file array. Accepts a
//   two-operand read request, drives one-hot read enables for one cycle,
//   samples the two bitline buses (forwarding same-edge write data), and
//   returns both operands over a valid/ready response handshake. While the
//   response waits, writes to the latched registers keep it coherent.
//
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     rp (slave)        request/response handshake bundle
//     rd_en1, rd_en2    one-hot row read enables to the array
//     bitline1/2        array bitline buses (only sampled in READ)
//     wr_en/addr/data   array write port, observed for bypass/coherency
//
//   ADDR_W must equal $clog2(NUM_REGS).
// ---------------------------------------------------------------------------
module regfile_read_port #(
  parameter int NUM_REGS = 16,
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  regfile_read_port_if.slave  rp,
  output logic [NUM_REGS-1:0] rd_en1,
  output logic [NUM_REGS-1:0] rd_en2,
  input  logic [WIDTH-1:0]    bitline1,
  input  logic [WIDTH-1:0]    bitline2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q,      state_d;
  logic [ADDR_W-1:0]   rs1_q,        rs1_d;
  logic [ADDR_W-1:0]   rs2_q,        rs2_d;
  logic                req_ready_q,  req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [NUM_REGS-1:0] rd_en1_q,     rd_en1_d;
  logic [NUM_REGS-1:0] rd_en2_q,     rd_en2_d;
  logic [WIDTH-1:0]    data1_q,      data1_d;
  logic [WIDTH-1:0]    data2_q,      data2_d;

  logic                wr_hit1;
  logic                wr_hit2;

  // Row select decoder: exactly one bit set for any address.
  function automatic logic [NUM_REGS-1:0] dec_onehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

  // A write landing on a latched register this edge; the cell flop updates
  // on the same edge, so its bitline still shows the old value.
  assign wr_hit1 = wr_en && (wr_addr == rs1_q);
  assign wr_hit2 = wr_en && (wr_addr == rs2_q);

  // Next-state, output and data-capture logic.
  always_comb begin
    state_d      = state_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    rd_en1_d     = '0;
    rd_en2_d     = '0;
    data1_d      = data1_q;
    data2_d      = data2_q;

    case (state_q)
      IDLE: begin
        if (rp.req_valid) begin
          state_d  = READ;
          rs1_d    = rp.req_rs1;
          rs2_d    = rp.req_rs2;
          // Registered here so the enables are live for the whole READ
          // cycle; they equal the decode of the addresses being latched.
          rd_en1_d = dec_onehot(rp.req_rs1);
          rd_en2_d = dec_onehot(rp.req_rs2);
        end else begin
          req_ready_d = 1'b1;
        end
      end

      READ: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        data1_d      = wr_hit1 ? wr_data : bitline1;
        data2_d      = wr_hit2 ? wr_data : bitline2;
      end

      RESP: begin
        // Coherency also applies on the handshake edge.
        data1_d = wr_hit1 ? wr_data : data1_q;
        data2_d = wr_hit2 ? wr_data : data2_q;
        if (rp.resp_ready) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end else begin
          resp_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State, latched addresses and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rs1_q        <= '0;
      rs2_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rd_en1_q     <= '0;
      rd_en2_q     <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
    end else begin
      state_q      <= state_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rd_en1_q     <= rd_en1_d;
      rd_en2_q     <= rd_en2_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
    end
  end

  assign rp.req_ready  = req_ready_q;
  assign rp.resp_valid = resp_valid_q;
  assign rp.resp_data1 = data1_q;
  assign rp.resp_data2 = data2_q;
  assign rd_en1        = rd_en1_q;
  assign rd_en2        = rd_en2_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// ---------------------------------------------------------------------------
// tb_regfile_read_port
//   Self-checking bench. Holds a behavioural model of the 16x16 array that
//   drives the bitlines from the enabled row and applies writes on the clock
//   edge. Expected operands follow from the rule that, from the capture edge
//   until the handshake edge, each response word equals the current content
//   of its addressed register.
// ---------------------------------------------------------------------------
module tb_regfile_read_port;

  localparam int NUM_REGS = 16;
  localparam int WIDTH    = 16;
  localparam int ADDR_W   = 4;

  logic                clk;
  logic                rst;
  logic [NUM_REGS-1:0] rd_en1;
  logic [NUM_REGS-1:0] rd_en2;
  logic [WIDTH-1:0]    bitline1;
  logic [WIDTH-1:0]    bitline2;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [WIDTH-1:0]    wr_data;

  logic [WIDTH-1:0]    mem [NUM_REGS];

  int n_cmp;
  int n_err;

  regfile_read_port_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) rif ();

  regfile_read_port #(
    .NUM_REGS (NUM_REGS),
    .WIDTH    (WIDTH),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rp       (rif),
    .rd_en1   (rd_en1),
    .rd_en2   (rd_en2),
    .bitline1 (bitline1),
    .bitline2 (bitline2),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: write port updates the cell on the rising edge.
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Array model: the enabled cell drives its bitline, otherwise floating.
  always_comb begin
    bitline1 = 16'hzzzz;
    bitline2 = 16'hzzzz;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_en1[i]) bitline1 = mem[i];
      if (rd_en2[i]) bitline2 = mem[i];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] row_bit(input logic [ADDR_W-1:0] a);
    return 32'd1 << a;
  endfunction

  task automatic write_reg(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // One full transaction, starting and ending at an IDLE-cycle negedge.
  //   resp_wait : RESP cycles with resp_ready=0 before the handshake cycle
  //   rd_wr     : write during READ (rd_wa/rd_wd)
  //   rsp_wr_k  : RESP cycle index of a directed write (-1 none)
  //   rnd_wr    : random writes during RESP cycles
  //   extra_req : keep a (random) request asserted during READ/RESP
  task automatic run_txn(
    input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2, input int resp_wait,
    input bit rd_wr, input logic [ADDR_W-1:0] rd_wa, input logic [WIDTH-1:0] rd_wd,
    input int rsp_wr_k, input logic [ADDR_W-1:0] rsp_wa, input logic [WIDTH-1:0] rsp_wd,
    input bit rnd_wr, input bit extra_req);
    check_val("idle_ready", {31'd0, rif.req_ready}, 32'd1);
    rif.req_valid = 1'b1;
    rif.req_rs1   = a1;
    rif.req_rs2   = a2;
    @(negedge clk);
    // READ cycle
    check_val("read_en1", {16'd0, rd_en1}, row_bit(a1));
    check_val("read_en2", {16'd0, rd_en2}, row_bit(a2));
    check_val("read_ready", {31'd0, rif.req_ready}, 32'd0);
    check_val("read_valid", {31'd0, rif.resp_valid}, 32'd0);
    rif.req_valid = extra_req;
    rif.req_rs1   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
    rif.req_rs2   = ADDR_W'($urandom_range(0, NUM_REGS - 1));
    wr_en   = rd_wr;
    wr_addr = rd_wa;
    wr_data = rd_wd;
    for (int k = 0; k <= resp_wait; k++) begin
      @(negedge clk);
      // RESP cycle k
      check_val("resp_valid", {31'd0, rif.resp_valid}, 32'd1);
      check_val("resp_ready_lo", {31'd0, rif.req_ready}, 32'd0);
      check_val("resp_en", {rd_en1, rd_en2}, 32'd0);
      check_val("resp_data1", {16'd0, rif.resp_data1}, {16'd0, mem[a1]});
      check_val("resp_data2", {16'd0, rif.resp_data2}, {16'd0, mem[a2]});
      wr_en = 1'b0;
      if (k == rsp_wr_k) begin
        wr_en   = 1'b1;
        wr_addr = rsp_wa;
        wr_data = rsp_wd;
      end else if (rnd_wr && ($urandom_range(0, 1) == 1)) begin
        wr_en   = 1'b1;
        case ($urandom_range(0, 2))
          0:       wr_addr = a1;
          1:       wr_addr = a2;
          default: wr_addr = ADDR_W'($urandom_range(0, NUM_REGS - 1));
        endcase
        wr_data = WIDTH'($urandom);
      end
      rif.resp_ready = (k == resp_wait);
      if (extra_req) begin
        rif.req_rs1 = ADDR_W'($urandom_range(0, NUM_REGS - 1));
        rif.req_rs2 = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      end
    end
    @(negedge clk);
    // First cycle back in IDLE: response gone, data held coherent to the handshake edge
    check_val("post_valid", {31'd0, rif.resp_valid}, 32'd0);
    check_val("post_ready", {31'd0, rif.req_ready}, 32'd1);
    check_val("post_en", {rd_en1, rd_en2}, 32'd0);
    check_val("post_data1", {16'd0, rif.resp_data1}, {16'd0, mem[a1]});
    check_val("post_data2", {16'd0, rif.resp_data2}, {16'd0, mem[a2]});
    wr_en          = 1'b0;
    rif.resp_ready = 1'b0;
    rif.req_valid  = 1'b0;
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst            = 1'b1;
    wr_en          = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    rif.req_valid  = 1'b0;
    rif.req_rs1    = '0;
    rif.req_rs2    = '0;
    rif.resp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_val("rst_ready", {31'd0, rif.req_ready}, 32'd1);
    check_val("rst_valid", {31'd0, rif.resp_valid}, 32'd0);
    check_val("rst_en", {rd_en1, rd_en2}, 32'd0);
    check_val("rst_data", {rif.resp_data1, rif.resp_data2}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NUM_REGS; i++) write_reg(ADDR_W'(i), WIDTH'($urandom));

    // Basic two-operand read
    write_reg(4'd3, 16'h1234);
    write_reg(4'd7, 16'hBEEF);
    run_txn(4'd3, 4'd7, 0, 1'b0, 4'd0, 16'h0, -1, 4'd0, 16'h0, 1'b0, 1'b0);
    check_val("basic_d1", {16'd0, rif.resp_data1}, 32'h1234);
    check_val("basic_d2", {16'd0, rif.resp_data2}, 32'hBEEF);

    // Same register on both ports
    write_reg(4'd5, 16'h00A5);
    run_txn(4'd5, 4'd5, 0, 1'b0, 4'd0, 16'h0, -1, 4'd0, 16'h0, 1'b0, 1'b0);
    check_val("same_d1", {16'd0, rif.resp_data1}, 32'h00A5);
    check_val("same_d2", {16'd0, rif.resp_data2}, 32'h00A5);

    // Write bypass at the READ capture edge
    write_reg(4'd2, 16'h1111);
    write_reg(4'd4, 16'h4444);
    run_txn(4'd2, 4'd4, 0, 1'b1, 4'd2, 16'h2222, -1, 4'd0, 16'h0, 1'b0, 1'b0);
    check_val("byp_d1", {16'd0, rif.resp_data1}, 32'h2222);
    check_val("byp_d2", {16'd0, rif.resp_data2}, 32'h4444);

    // Coherency while the response is stalled
    write_reg(4'd9, 16'h0009);
    run_txn(4'd9, 4'd9, 3, 1'b0, 4'd0, 16'h0, 1, 4'd9, 16'hCAFE, 1'b0, 1'b0);
    check_val("coh_d1", {16'd0, rif.resp_data1}, 32'hCAFE);
    check_val("coh_d2", {16'd0, rif.resp_data2}, 32'hCAFE);

    // Request held during READ/RESP is ignored
    run_txn(4'd1, 4'd14, 2, 1'b0, 4'd0, 16'h0, -1, 4'd0, 16'h0, 1'b0, 1'b1);

    // Reset in the READ cycle aborts the transaction
    rif.req_valid = 1'b1;
    rif.req_rs1   = 4'd6;
    rif.req_rs2   = 4'd12;
    @(negedge clk);
    check_val("abort_en1", {16'd0, rd_en1}, 32'h0040);
    rif.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_en", {rd_en1, rd_en2}, 32'd0);
    check_val("abort_valid", {31'd0, rif.resp_valid}, 32'd0);
    check_val("abort_ready", {31'd0, rif.req_ready}, 32'd1);
    check_val("abort_data", {rif.resp_data1, rif.resp_data2}, 32'd0);
    @(negedge clk);
    check_val("abort_hold_valid", {31'd0, rif.resp_valid}, 32'd0);

    // Randomized transactions
    for (int t = 0; t < 60; t++) begin
      logic [ADDR_W-1:0] a1;
      logic [ADDR_W-1:0] a2;
      logic [ADDR_W-1:0] wa;
      a1 = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : ADDR_W'($urandom_range(0, NUM_REGS - 1));
      wa = ($urandom_range(0, 1) == 1) ? a2 : a1;
      if ($urandom_range(0, 2) == 0) wa = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      run_txn(a1, a2, $urandom_range(0, 3), 1'($urandom_range(0, 1)), wa, WIDTH'($urandom),
              -1, 4'd0, 16'h0, 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read-side sequencer for the bit-cell register file array (16 registers x 16 bits, two shared bitline buses per bit column).
- Accepts a two-operand read request over a valid/ready handshake and drives one-hot read enables for the addressed registers. It samples the two bitline buses, forwards any same-cycle write-port data, and returns both operands over a valid/ready response handshake.
- Sits between decode and the register array; it is the only agent that drives the array read enables.

Parameters:
- NUM_REGS, 16, number of registers (one read-enable pair per register)
- WIDTH, 16, bits per register / bitline bus width
- ADDR_W, 4, register address width; must equal clog2(NUM_REGS)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  read request present
- req_ready  output  1  block can accept a request
- req_rs1  input  ADDR_W  port-1 register address
- req_rs2  input  ADDR_W  port-2 register address
- rd_en1  output  NUM_REGS  one-hot ReadEnable1 to array rows
- rd_en2  output  NUM_REGS  one-hot ReadEnable2 to array rows
- bitline1  input  WIDTH  array Bitline1 bus (tri-stated by cells; high-Z when no row enabled)
- bitline2  input  WIDTH  array Bitline2 bus
- wr_en  input  1  array write-port enable (observed for bypass only)
- wr_addr  input  ADDR_W  array write address
- wr_data  input  WIDTH  array write data
- resp_valid  output  1  operand data valid
- resp_ready  input  1  consumer accepts response
- resp_data1  output  WIDTH  operand for req_rs1
- resp_data2  output  WIDTH  operand for req_rs2

Behaviour:
- Reset state, held while rst=1 at any edge:
  - state=IDLE, req_ready=1, rd_en1=rd_en2=0, resp_valid=0, resp_data1=resp_data2=0.
  - Latched addresses are cleared to 0.
- States: IDLE, READ, RESP.
- IDLE:
  - req_ready=1; rd_en1=rd_en2=0.
  - On req_valid=1: latch rs1/rs2 and go to READ. Otherwise stay in IDLE.
- READ (exactly one cycle):
  - req_ready=0.
  - rd_en1 = one-hot of latched rs1; rd_en2 = one-hot of latched rs2. rs1==rs2 is legal: both ports enable the same row.
  - At the closing edge, capture data into resp_data1/2 and go to RESP:
    - bitline capture for each port;
    - except when wr_en=1 and wr_addr equals that port's latched address, capture wr_data instead. This bypass is needed because the cell flop updates at that same edge, so the bitline still shows the old value.
- RESP:
  - resp_valid=1; rd_en1=rd_en2=0; req_ready=0.
  - Coherency: any edge with wr_en=1 and wr_addr matching a latched address overwrites the corresponding resp_data with wr_data. This applies to both ports when addresses match, and to edges where resp_ready=1.
  - resp_ready=1 -> IDLE at that edge; resp_valid drops next cycle.
  - resp_data holds its value after the handshake until the next capture.
- Latency: request accepted at edge N -> resp_valid high from the cycle after edge N+1. Best-case throughput is one request per 3 cycles.
- Bitlines are never sampled outside READ; X/Z on bitlines in other states must not propagate.
- Enables are registered/decoded from latched addresses only, never combinationally from req_*.
- At most one bit of each of rd_en1 and rd_en2 is high in any cycle.
- Reset mid-READ or mid-RESP aborts the transaction: enables drop and resp_valid=0 the next cycle; no response is delivered.
- req_valid while not in IDLE is ignored; the requester must hold the request until req_ready=1.

Test Plan:
- Reset, then array R3=0x1234, R7=0xBEEF; request rs1=3, rs2=7 -> READ cycle shows rd_en1=0x0008, rd_en2=0x0080; then resp_valid=1 with resp_data1=0x1234, resp_data2=0xBEEF.
- Same-register read: rs1=rs2=5, R5=0x00A5 -> rd_en1=rd_en2=0x0020; both outputs 0x00A5.
- Bypass in READ: R2=0x1111, request rs1=2, rs2=4 (R4=0x4444); during READ drive wr_en=1, wr_addr=2, wr_data=0x2222 -> resp_data1=0x2222, resp_data2=0x4444.
- Coherency in RESP: hold resp_ready=0 for 3 cycles after resp_valid (rs1=rs2=9, R9=0x0009). Write R9=0xCAFE in the second RESP cycle -> both outputs 0xCAFE from the next cycle. After resp_ready=1: IDLE, resp_valid=0.
- Backpressure/ignore: second req_valid asserted during READ/RESP -> req_ready=0 and no address change. The request is accepted only in the IDLE cycle after the handshake; rd_en never has more than one bit set.
- Reset mid-READ: assert rst in the READ cycle -> next cycle rd_en1=rd_en2=0, resp_valid=0, req_ready=1, resp_data=0.
